// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------------------+
// | mips_mem_arbiter : round-robin fetch/data arbiter onto one single-port word memory     |
// | Revision 1.0                                                                           |
// +----------------------------------------------------------------------------------------+
module mips_mem_arbiter #(
  parameter int MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_byte_en,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic        mem_wr_en,
  output logic        mem_read_en,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [32:0] c_MEM_LIMIT = 33'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_I_RESP = 2'd1,
    S_D_RESP = 2'd2
  } state_t;

  state_t state_q;
  logic   rr_data_q;   // 1: data port wins the next contended arbitration
  logic   err_q;
  logic   rd_q;

  logic w_idle, w_gnt_d, w_gnt_i, w_d_ok, w_i_ok, w_d_rd, w_d_wr;

  function automatic logic f_bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (({1'b0, a} + 33'd3) >= c_MEM_LIMIT);
  endfunction

  assign w_idle  = (state_q == S_IDLE) && !reset;
  assign w_gnt_d = w_idle && d_req && (!i_req || rr_data_q);
  assign w_gnt_i = w_idle && i_req && !w_gnt_d;
  assign w_d_ok  = w_gnt_d && !f_bad_addr(d_addr);
  assign w_i_ok  = w_gnt_i && !f_bad_addr(i_addr);
  assign w_d_rd  = w_d_ok && !d_we;
  assign w_d_wr  = w_d_ok && d_we;

  // Issue cycle: memory is driven straight from the granted port
  assign mem_read_en = w_i_ok || w_d_rd;
  assign mem_wr_en   = w_d_wr;
  assign mem_address = w_i_ok ? i_addr : (w_d_ok ? d_addr : 32'd0);
  assign mem_byte_en = mem_read_en ? 4'hF : (w_d_wr ? d_byte_en : 4'h0);
  assign mem_data_in = w_d_wr ? d_wdata : 32'd0;

  // Response pulses are masked by reset so an interrupted transaction never completes
  assign i_ack   = (state_q == S_I_RESP) && !err_q && !reset;
  assign i_err   = (state_q == S_I_RESP) &&  err_q && !reset;
  assign d_ack   = (state_q == S_D_RESP) && !err_q && !reset;
  assign d_err   = (state_q == S_D_RESP) &&  err_q && !reset;
  assign i_rdata = i_ack ? mem_data_out : 32'd0;
  assign d_rdata = (d_ack && rd_q) ? mem_data_out : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_data_q <= 1'b1;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_gnt_d) begin
            state_q <= S_D_RESP;
            err_q   <= f_bad_addr(d_addr);
            rd_q    <= !d_we;
            if (i_req) rr_data_q <= 1'b0;
          end else if (w_gnt_i) begin
            state_q <= S_I_RESP;
            err_q   <= f_bad_addr(i_addr);
            rd_q    <= 1'b1;
            if (d_req) rr_data_q <= 1'b1;
          end
        end
        S_I_RESP, S_D_RESP: state_q <= S_IDLE;
        default:            state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------------------+
// | tb_mips_mem_arbiter : directed bench with a behavioural big-endian word memory         |
// | Revision 1.0                                                                           |
// +----------------------------------------------------------------------------------------+
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_byte_en = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  logic        mem_wr_en, mem_read_en;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  logic [31:0] mem [0:511];

  mips_mem_arbiter #(.MEM_BYTES(2048)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byte_en(d_byte_en), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_read_en(mem_read_en),
    .mem_byte_en(mem_byte_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  initial for (int k = 0; k < 512; k++) mem[k] = 32'd0;

  always @(posedge clk) begin
    if (mem_wr_en)
      for (int b = 0; b < 4; b++)
        if (mem_byte_en[b]) mem[mem_address[10:2]][8*b +: 8] <= mem_data_in[8*b +: 8];
    if (mem_read_en) mem_data_out <= mem[mem_address[10:2]];
  end

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output logic ack, output logic err,
                         output logic [31:0] rd, output logic iss_rd, output logic iss_wr,
                         output int lat);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = addr; d_byte_en = be; d_wdata = wd;
    #1;
    iss_rd = mem_read_en; iss_wr = mem_wr_en;
    lat = 0; ack = 1'b0; err = 1'b0; rd = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      lat++;
      if (d_ack || d_err) begin
        ack = d_ack; err = d_err; rd = d_rdata;
        break;
      end
    end
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_byte_en = '0; d_wdata = '0;
  endtask

  task automatic do_fetch(input logic [31:0] addr, output logic ack, output logic err,
                          output logic [31:0] rd, output logic iss_rd, output int lat);
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = addr;
    #1;
    iss_rd = mem_read_en;
    lat = 0; ack = 1'b0; err = 1'b0; rd = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      lat++;
      if (i_ack || i_err) begin
        ack = i_ack; err = i_err; rd = i_rdata;
        break;
      end
    end
    i_req = 1'b0; i_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'd16;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if ({mem_read_en, mem_wr_en} !== 2'b00) begin n_bad++;
      $display("FAIL reset_strobes: got %b expected 00", {mem_read_en, mem_wr_en}); end
    n_cmp++; if ({i_ack, i_err, d_ack, d_err} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_resp: got %b expected 0000", {i_ack, i_err, d_ack, d_err}); end
    n_cmp++; if ({i_rdata, d_rdata} !== 64'd0) begin n_bad++;
      $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata}); end
    i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++; if ({mem_read_en, mem_address} !== 33'd0) begin n_bad++;
      $display("FAIL idle_no_req: got %h expected 0", {mem_read_en, mem_address}); end
  endtask

  task automatic test_write_read();
    logic ack, err, ird, iwr; logic [31:0] rd; int lat, w_cyc;
    do_data(1'b1, 32'd8, 4'hF, 32'h0000004F, ack, err, rd, ird, iwr, lat);
    w_cyc = cyc_cnt;
    n_cmp++; if ({ack, err, iwr, ird} !== 4'b1010 || lat != 1) begin n_bad++;
      $display("FAIL wr8: got ack/err/wr/rd=%b lat=%0d expected 1010 lat=1", {ack, err, iwr, ird}, lat); end
    do_data(1'b0, 32'd8, 4'h0, 32'd0, ack, err, rd, ird, iwr, lat);
    n_cmp++; if ({ack, err, iwr, ird} !== 4'b1001 || cyc_cnt - w_cyc != 2) begin n_bad++;
      $display("FAIL rd8_timing: got ack/err/wr/rd=%b dist=%0d expected 1001 dist=2", {ack, err, iwr, ird}, cyc_cnt - w_cyc); end
    n_cmp++; if (rd !== 32'h0000004F) begin n_bad++;
      $display("FAIL rd8_data: got %h expected 0000004f", rd); end
  endtask

  task automatic test_partial();
    logic ack, err, ird, iwr; logic [31:0] rd; int lat;
    do_data(1'b1, 32'd16, 4'hF, 32'h11223344, ack, err, rd, ird, iwr, lat);
    do_data(1'b1, 32'd16, 4'b0011, 32'hAABBCCDD, ack, err, rd, ird, iwr, lat);
    do_data(1'b0, 32'd16, 4'h0, 32'd0, ack, err, rd, ird, iwr, lat);
    n_cmp++; if (rd !== 32'h1122CCDD || ack !== 1'b1) begin n_bad++;
      $display("FAIL partial_rd: got %h ack=%b expected 1122ccdd ack=1", rd, ack); end
    do_data(1'b1, 32'd16, 4'b0000, 32'hFFFFFFFF, ack, err, rd, ird, iwr, lat);
    n_cmp++; if ({ack, err} !== 2'b10 || lat != 1) begin n_bad++;
      $display("FAIL be0_wr: got ack/err=%b lat=%0d expected 10 lat=1", {ack, err}, lat); end
    do_data(1'b0, 32'd16, 4'h0, 32'd0, ack, err, rd, ird, iwr, lat);
    n_cmp++; if (rd !== 32'h1122CCDD) begin n_bad++;
      $display("FAIL be0_rd: got %h expected 1122ccdd", rd); end
  endtask

  task automatic test_fetch();
    logic ack, err, ird, iwr; logic [31:0] rd; int lat;
    do_fetch(32'd16, ack, err, rd, ird, lat);
    n_cmp++; if ({ack, err, ird} !== 3'b101 || lat != 1 || rd !== 32'h1122CCDD) begin n_bad++;
      $display("FAIL fetch16: got ack/err/rd=%b lat=%0d data=%h expected 101 lat=1 data=1122ccdd", {ack, err, ird}, lat, rd); end
    do_data(1'b1, 32'd2044, 4'hF, 32'hCAFEF00D, ack, err, rd, ird, iwr, lat);
    n_cmp++; if ({ack, err, iwr} !== 3'b101) begin n_bad++;
      $display("FAIL wr_last_word: got ack/err/wr=%b expected 101", {ack, err, iwr}); end
    do_fetch(32'd2044, ack, err, rd, ird, lat);
    n_cmp++; if ({ack, err} !== 2'b10 || rd !== 32'hCAFEF00D) begin n_bad++;
      $display("FAIL fetch_last_word: got ack/err=%b data=%h expected 10 cafef00d", {ack, err}, rd); end
  endtask

  task automatic test_errors();
    logic ack, err, ird, iwr; logic [31:0] rd; int lat;
    do_data(1'b0, 32'd6, 4'h0, 32'd0, ack, err, rd, ird, iwr, lat);
    n_cmp++; if ({ack, err, ird, iwr} !== 4'b0100 || lat != 1 || rd !== 32'd0) begin n_bad++;
      $display("FAIL misaligned_rd: got ack/err/rd/wr=%b lat=%0d data=%h expected 0100 lat=1 data=0", {ack, err, ird, iwr}, lat, rd); end
    do_fetch(32'd2048, ack, err, rd, ird, lat);
    n_cmp++; if ({ack, err, ird} !== 3'b010 || rd !== 32'd0) begin n_bad++;
      $display("FAIL range_fetch: got ack/err/rd=%b data=%h expected 010 data=0", {ack, err, ird}, rd); end
    do_data(1'b1, 32'd2048, 4'hF, 32'h12345678, ack, err, rd, ird, iwr, lat);
    n_cmp++; if ({ack, err, iwr} !== 3'b010) begin n_bad++;
      $display("FAIL range_wr: got ack/err/wr=%b expected 010", {ack, err, iwr}); end
    do_fetch(32'd2046, ack, err, rd, ird, lat);
    n_cmp++; if ({ack, err, ird} !== 3'b010) begin n_bad++;
      $display("FAIL misaligned_fetch: got ack/err/rd=%b expected 010", {ack, err, ird}); end
  endtask

  task automatic test_contention();
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'd16;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      n_cmp++; if ({d_ack, i_ack} !== {k % 4 == 0, k % 4 == 2}) begin n_bad++;
        $display("FAIL rr_step%0d: got d_ack/i_ack=%b expected %b", k, {d_ack, i_ack}, {k % 4 == 0, k % 4 == 2}); end
      if (k % 4 == 0) begin
        n_cmp++; if (d_rdata !== 32'h0000004F) begin n_bad++;
          $display("FAIL rr_ddata%0d: got %h expected 0000004f", k, d_rdata); end
      end
      if (k % 4 == 2) begin
        n_cmp++; if (i_rdata !== 32'h1122CCDD) begin n_bad++;
          $display("FAIL rr_idata%0d: got %h expected 1122ccdd", k, i_rdata); end
      end
    end
    i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_resp();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd8;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp++; if ({d_ack, d_err, d_rdata} !== 34'd0) begin n_bad++;
      $display("FAIL rst_resp_suppress: got %h expected 0", {d_ack, d_err, d_rdata}); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (mem_read_en !== 1'b1 || mem_address !== 32'd8) begin n_bad++;
      $display("FAIL rst_reissue: got rd=%b addr=%h expected 1 00000008", mem_read_en, mem_address); end
    @(posedge clk); #1;
    n_cmp++; if (d_ack !== 1'b1 || d_rdata !== 32'h0000004F) begin n_bad++;
      $display("FAIL rst_reissue_ack: got ack=%b data=%h expected 1 0000004f", d_ack, d_rdata); end
    d_req = 1'b0; d_addr = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_fetch();
    test_errors();
    test_contention();
    test_reset_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
